// File: rtl/midi_decode_if.sv
// midi_decode_if: bundles the FIFO-side handshake and the decoded-note
// outputs of midi_decode into one port.
//   FIFO side   : message, FIFOFull, FIFOEmpty, DataValid (to decoder), read (from decoder)
//   Decode side : decodeType, messageValid, waveReady, messageType, delay, velocity
//   slave  modport - the decoder's view
//   master modport - the view of whoever feeds the FIFO and consumes the note
interface midi_decode_if;
   logic [7:0] message;
   logic       FIFOFull;
   logic       FIFOEmpty;
   logic       DataValid;
   logic       read;
   logic [1:0] decodeType;
   logic       messageValid;
   logic       waveReady;
   logic       messageType;
   logic [9:0] delay;
   logic [7:0] velocity;

   modport slave (
      input  message, FIFOFull, FIFOEmpty, DataValid,
      output read, decodeType, messageValid, waveReady, messageType, delay, velocity
   );

   modport master (
      output message, FIFOFull, FIFOEmpty, DataValid,
      input  read, decodeType, messageValid, waveReady, messageType, delay, velocity
   );
endinterface

// File: rtl/midi_decode.sv
// midi_decode: pops bytes from a first-word-fall-through MIDI receive FIFO and
// assembles Note On / Note Off messages (status, note, velocity). Each complete
// message produces a one-cycle messageValid/waveReady strobe together with the
// note on/off flag, a 10-bit tone half-period code and the 7-bit velocity.
// Ports:
//   Clock - system clock, rising edge
//   Reset - synchronous, active-high
//   bus   - midi_decode_if.slave: FIFO head byte and flags in, pop strobe,
//           byte classification and decoded note outputs out
module midi_decode (
   input logic         Clock,
   input logic         Reset,
   midi_decode_if.slave bus
);

   typedef enum logic [1:0] {
      S_STATUS,
      S_NOTE,
      S_VEL,
      S_DONE
   } stateT;

   localparam logic [1:0] DT_OTHER    = 2'b00;
   localparam logic [1:0] DT_NOTE_OFF = 2'b01;
   localparam logic [1:0] DT_NOTE_ON  = 2'b10;
   localparam logic [1:0] DT_DATA     = 2'b11;

   stateT      state;
   logic       typeOn;        // latched status: 1 = Note On, 0 = Note Off
   logic [6:0] noteReg;
   logic       messageValidReg;
   logic       messageTypeReg;
   logic [9:0] delayReg;
   logic [7:0] velocityReg;

   logic       avail;
   logic [1:0] decodeType;
   logic       isNoteStatus;
   logic [6:0] noteRem;
   logic [3:0] octave;
   logic [9:0] baseVal;
   logic [9:0] delayNext;

   // Channel nibble is ignored: only the upper nibble selects the type.
   always_comb begin
      decodeType = DT_OTHER;
      if (!bus.message[7])
         decodeType = DT_DATA;
      else if (bus.message[7:4] == 4'h8)
         decodeType = DT_NOTE_OFF;
      else if (bus.message[7:4] == 4'h9)
         decodeType = DT_NOTE_ON;
   end

   assign isNoteStatus = (decodeType == DT_NOTE_OFF) || (decodeType == DT_NOTE_ON);
   assign avail        = bus.DataValid & ~bus.FIFOEmpty;
   // The strobe cycle never pops, so a message always costs at least 4 cycles.
   assign bus.read       = avail && (state != S_DONE);
   assign bus.decodeType = decodeType;

   // Octave/semitone split of the note: restoring compare/subtract against
   // 12 shifted by 3,2,1,0. A 7-bit note gives an octave of at most 10.
   // NOTE: combinational blocks use blocking '=' so each step sees the
   // previous step's remainder within the same evaluation.
   always_comb begin
      noteRem = noteReg;
      octave  = 4'd0;
      if (noteRem >= 7'd96) begin
         noteRem   = noteRem - 7'd96;
         octave[3] = 1'b1;
      end
      if (noteRem >= 7'd48) begin
         noteRem   = noteRem - 7'd48;
         octave[2] = 1'b1;
      end
      if (noteRem >= 7'd24) begin
         noteRem   = noteRem - 7'd24;
         octave[1] = 1'b1;
      end
      if (noteRem >= 7'd12) begin
         noteRem   = noteRem - 7'd12;
         octave[0] = 1'b1;
      end
   end

   // Half-period codes for octave 0, C through B.
   always_comb begin
      baseVal = 10'd1023;
      case (noteRem)
         7'd0:    baseVal = 10'd1023;
         7'd1:    baseVal = 10'd966;
         7'd2:    baseVal = 10'd911;
         7'd3:    baseVal = 10'd860;
         7'd4:    baseVal = 10'd812;
         7'd5:    baseVal = 10'd766;
         7'd6:    baseVal = 10'd723;
         7'd7:    baseVal = 10'd683;
         7'd8:    baseVal = 10'd644;
         7'd9:    baseVal = 10'd608;
         7'd10:   baseVal = 10'd574;
         7'd11:   baseVal = 10'd542;
         default: baseVal = 10'd1023;
      endcase
   end

   assign delayNext = baseVal >> octave;

   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state           <= S_STATUS;
         typeOn          <= 1'b0;
         noteReg         <= 7'd0;
         messageValidReg <= 1'b0;
         messageTypeReg  <= 1'b0;
         delayReg        <= 10'd0;
         velocityReg     <= 8'd0;
      end else begin
         messageValidReg <= 1'b0;
         case (state)
            S_STATUS: begin
               if (avail && isNoteStatus) begin
                  typeOn <= (decodeType == DT_NOTE_ON);
                  state  <= S_NOTE;
               end
            end
            S_NOTE: begin
               if (avail) begin
                  if (decodeType == DT_DATA) begin
                     noteReg <= bus.message[6:0];
                     state   <= S_VEL;
                  end else if (isNoteStatus) begin
                     typeOn <= (decodeType == DT_NOTE_ON);
                  end else begin
                     state <= S_STATUS;
                  end
               end
            end
            S_VEL: begin
               if (avail) begin
                  if (decodeType == DT_DATA) begin
                     // Note On with velocity 0 is treated as a note off.
                     messageTypeReg  <= typeOn && (bus.message[6:0] != 7'd0);
                     delayReg        <= delayNext;
                     velocityReg     <= {1'b0, bus.message[6:0]};
                     messageValidReg <= 1'b1;
                     state           <= S_DONE;
                  end else if (isNoteStatus) begin
                     typeOn <= (decodeType == DT_NOTE_ON);
                     state  <= S_NOTE;
                  end else begin
                     state <= S_STATUS;
                  end
               end
            end
            S_DONE: begin
               state <= S_STATUS;
            end
            default: begin
               state <= S_STATUS;
            end
         endcase
      end
   end

   assign bus.messageValid = messageValidReg;
   assign bus.waveReady    = messageValidReg;
   assign bus.messageType  = messageTypeReg;
   assign bus.delay        = delayReg;
   assign bus.velocity     = velocityReg;

endmodule

// File: tb/tb_midi_decode.sv
// tb_midi_decode: directed, table-driven bench for midi_decode. Inputs change
// and outputs are sampled 1 time unit after the falling clock edge.
module tb_midi_decode;

   logic Clock;
   logic Reset;
   int   tests;
   int   fails;

   midi_decode_if bus ();

   midi_decode dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      string      name;
      int         n;
      logic [7:0] b [6];
      logic       expType;
      int         expDelay;
      int         expVel;
   } vecT;

   vecT vecs [10];

   task automatic check(input string name, input int actual, input int expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic setVec(input int i, input string name, input int n,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                         input logic t, input int d, input int v);
      vecs[i].name     = name;
      vecs[i].n        = n;
      vecs[i].b[0]     = b0;
      vecs[i].b[1]     = b1;
      vecs[i].b[2]     = b2;
      vecs[i].b[3]     = b3;
      vecs[i].b[4]     = b4;
      vecs[i].b[5]     = b5;
      vecs[i].expType  = t;
      vecs[i].expDelay = d;
      vecs[i].expVel   = v;
   endtask

   // Called just after a falling edge; returns just after the falling edge
   // that follows the consuming rising edge. waits = cycles read stayed low.
   task automatic pushByte(input logic [7:0] b, output int waits);
      bus.message   = b;
      bus.DataValid = 1'b1;
      bus.FIFOEmpty = 1'b0;
      waits = 0;
      #1;
      while (!bus.read && waits < 8) begin
         @(negedge Clock);
         #1;
         waits++;
      end
      if (!bus.read)
         check("push_timeout", 0, 1);
      else
         @(negedge Clock);
   endtask

   task automatic idle();
      bus.DataValid = 1'b0;
      bus.FIFOEmpty = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int waitSum;
      logic [7:0] dtMsg [8];
      int         dtExp [8];

      tests = 0;
      fails = 0;
      bus.message  = 8'h00;
      bus.FIFOFull = 1'b0;
      idle();
      Reset = 1'b1;

      setVec(0, "note_on_d",      3, 8'h92, 8'h1A, 8'h0C, 8'h00, 8'h00, 8'h00, 1'b1, 227, 12);
      setVec(1, "note_on_ch7",    3, 8'h97, 8'h0F, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b1, 430, 60);
      setVec(2, "sysex_skip",     4, 8'hF0, 8'h80, 8'h1F, 8'h03, 8'h00, 8'h00, 1'b0, 170, 3);
      setVec(3, "vel0_off",       3, 8'h90, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 31,  0);
      setVec(4, "restart_note",   4, 8'h90, 8'h80, 8'h3C, 8'h40, 8'h00, 8'h00, 1'b0, 31,  64);
      setVec(5, "data_first_max", 4, 8'h3C, 8'h95, 8'h7F, 8'h7F, 8'h00, 8'h00, 1'b1, 0,   127);
      setVec(6, "note0",          3, 8'h90, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1023, 1);
      setVec(7, "restart_vel",    5, 8'h90, 8'h10, 8'h91, 8'h0B, 8'h05, 8'h00, 1'b1, 542, 5);
      setVec(8, "other_in_vel",   6, 8'h90, 8'h10, 8'hA0, 8'h90, 8'h0C, 8'h09, 1'b1, 511, 9);
      setVec(9, "other_in_note",  5, 8'h90, 8'hFF, 8'h80, 8'h0D, 8'h02, 8'h00, 1'b0, 483, 2);

      dtMsg[0] = 8'h00; dtExp[0] = 3;
      dtMsg[1] = 8'h7F; dtExp[1] = 3;
      dtMsg[2] = 8'h80; dtExp[2] = 1;
      dtMsg[3] = 8'h8F; dtExp[3] = 1;
      dtMsg[4] = 8'h90; dtExp[4] = 2;
      dtMsg[5] = 8'h9F; dtExp[5] = 2;
      dtMsg[6] = 8'hA0; dtExp[6] = 0;
      dtMsg[7] = 8'hFF; dtExp[7] = 0;

      // Reset state
      repeat (2) @(negedge Clock);
      #1;
      check("rst_read",         bus.read,         0);
      check("rst_messageValid", bus.messageValid, 0);
      check("rst_waveReady",    bus.waveReady,    0);
      check("rst_messageType",  bus.messageType,  0);
      check("rst_delay",        bus.delay,        0);
      check("rst_velocity",     bus.velocity,     0);
      Reset = 1'b0;
      @(negedge Clock);

      // Byte classification (no byte offered, so nothing is consumed)
      for (int i = 0; i < 8; i++) begin
         bus.message = dtMsg[i];
         #1;
         check($sformatf("decodeType_%02h", dtMsg[i]), bus.decodeType, dtExp[i]);
         check($sformatf("decodeType_noread_%02h", dtMsg[i]), bus.read, 0);
      end
      @(negedge Clock);

      // Table of complete messages
      for (int i = 0; i < 10; i++) begin
         waitSum = 0;
         for (int j = 0; j < vecs[i].n; j++) begin
            pushByte(vecs[i].b[j], w);
            waitSum += w;
         end
         check({vecs[i].name, "_read_waits"}, waitSum, 0);
         // Strobe cycle: offer another byte, it must not be popped.
         bus.message = 8'hF8;
         #1;
         check({vecs[i].name, "_done_noread"}, bus.read,         0);
         check({vecs[i].name, "_valid"},       bus.messageValid, 1);
         check({vecs[i].name, "_waveReady"},   bus.waveReady,    1);
         check({vecs[i].name, "_type"},        bus.messageType,  vecs[i].expType);
         check({vecs[i].name, "_delay"},       bus.delay,        vecs[i].expDelay);
         check({vecs[i].name, "_velocity"},    bus.velocity,     vecs[i].expVel);
         idle();
         @(negedge Clock);
         #1;
         check({vecs[i].name, "_valid_drop"}, bus.messageValid, 0);
         check({vecs[i].name, "_delay_hold"}, bus.delay,        vecs[i].expDelay);
         @(negedge Clock);
      end

      // FIFO empty stall between note and velocity
      pushByte(8'h90, w);
      pushByte(8'h40, w);
      bus.message   = 8'h50;
      bus.DataValid = 1'b1;
      bus.FIFOEmpty = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("stall_read_%0d", k),  bus.read,         0);
         check($sformatf("stall_valid_%0d", k), bus.messageValid, 0);
         @(negedge Clock);
      end
      pushByte(8'h50, w);
      check("stall_wait", w, 0);
      #1;
      check("stall_valid",    bus.messageValid, 1);
      check("stall_type",     bus.messageType,  1);
      check("stall_delay",    bus.delay,        25);
      check("stall_velocity", bus.velocity,     80);
      idle();
      repeat (2) @(negedge Clock);

      // Reset in the middle of a message
      pushByte(8'h90, w);
      pushByte(8'h30, w);
      idle();
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      check("midrst_valid",    bus.messageValid, 0);
      check("midrst_type",     bus.messageType,  0);
      check("midrst_delay",    bus.delay,        0);
      check("midrst_velocity", bus.velocity,     0);
      pushByte(8'h45, w);
      check("midrst_45_popped", w, 0);
      idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("midrst_nostrobe_%0d", k), bus.messageValid, 0);
         check($sformatf("midrst_vel_%0d", k),      bus.velocity,     0);
         @(negedge Clock);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
